// File: rtl/fpmul_arbiter_if.sv
// Handshake bundle between two operand requesters, the shared-multiplier
// arbiter and the response consumer.
interface fpmul_arbiter_if;
    logic        req0_valid;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ready;

    logic        req1_valid;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ready;

    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_special;

    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_a, req1_b, input req1_ready,
        input  rsp_valid, output rsp_ready,
        input  rsp_id, rsp_data, rsp_special, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_a, req1_b, output req1_ready,
        output rsp_valid, input rsp_ready,
        output rsp_id, rsp_data, rsp_special, busy
    );
endinterface

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin arbiter in front of one shared single-precision
// multiplier; operands are captured, multiplied for EXEC_CYCLES, then returned.
module multiplierunit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] dataR,
    output logic [4:0]  casesspecial
);
    logic              sign;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] exp_sum;
    logic signed [9:0] exp_fin;
    logic [22:0]       mant;
    logic              guard, sticky, round_up;
    logic [23:0]       mant_rnd;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    // Subnormal operands are flushed to zero.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == '0);
    assign b_inf  = (eb == 8'hFF) && (fb == '0);
    assign a_nan  = (ea == 8'hFF) && (fa != '0);
    assign b_nan  = (eb == 8'hFF) && (fb != '0);

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
        dataR        = '0;
        casesspecial = 5'b00000;
        prod         = {1'b1, fa} * {1'b1, fb};
        exp_sum      = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            mant    = prod[46:24];
            guard   = prod[23];
            sticky  = |prod[22:0];
            exp_sum = exp_sum + 10'sd1;
        end else begin
            mant    = prod[45:23];
            guard   = prod[22];
            sticky  = |prod[21:0];
        end
        // Round to nearest, ties to even; a carry out bumps the exponent.
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, round_up};
        exp_fin  = exp_sum + $signed({9'd0, mant_rnd[23]});

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            dataR        = 32'h7FC0_0000;
            casesspecial = 5'b00001;
        end else if (a_inf || b_inf || (exp_fin >= 10'sd255)) begin
            dataR        = {sign, 8'hFF, 23'd0};
            casesspecial = sign ? 5'b00010 : 5'b00100;
        end else if (a_zero || b_zero || (exp_fin <= 10'sd0)) begin
            dataR        = {sign, 31'd0};
            casesspecial = sign ? 5'b01000 : 5'b10000;
        end else begin
            dataR        = {sign, exp_fin[7:0], mant_rnd[22:0]};
        end
    end
endmodule

module fpmul_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    fpmul_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state;
    logic        ptr;
    logic [3:0]  cnt;
    logic [31:0] a_q, b_q;
    logic        id_q;
    logic        rsp_valid_q, rsp_id_q, busy_q;
    logic [31:0] rsp_data_q;
    logic [4:0]  rsp_special_q;
    logic        grant0, grant1;
    logic [31:0] mul_data;
    logic [4:0]  mul_special;

    // The pointer only breaks ties; a lone requester is always granted.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
    assign grant1 = bus.req1_valid & (~bus.req0_valid |  ptr);

    assign bus.req0_ready  = rst_n & (state == IDLE) & grant0;
    assign bus.req1_ready  = rst_n & (state == IDLE) & grant1;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_special = rsp_special_q;
    assign bus.busy        = busy_q;

    multiplierunit u_mul (
        .a            (a_q),
        .b            (b_q),
        .dataR        (mul_data),
        .casesspecial (mul_special)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= 1'b0;
            cnt           <= '0;
            // NOTE: operand registers are reset as well, so a reset mid-flight leaves nothing stale to replay.
            a_q           <= '0;
            b_q           <= '0;
            id_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_special_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_ready || bus.req1_ready) begin
                        a_q    <= bus.req1_ready ? bus.req1_a : bus.req0_a;
                        b_q    <= bus.req1_ready ? bus.req1_b : bus.req0_b;
                        id_q   <= bus.req1_ready;
                        cnt    <= CNT_LOAD;
                        busy_q <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data_q    <= mul_data;
                        rsp_special_q <= mul_special;
                        rsp_id_q      <= id_q;
                        rsp_valid_q   <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ptr         <= ~rsp_id_q;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
